rf_writeback_arbiter: RTL and testbench

//  Write-side master for the Register_File single write port (RW_RF/DW_RF/WE_RF).

---
 rtl/rf_writeback_arbiter.sv | 152 +++++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// Write-side master for the register file: merges ALU results and buffered load returns into one registered write per cycle.
// Optional build macro WB_LOAD_BYPASS_EN lets a load skip the empty FIFO and write one cycle earlier.
module rf_writeback_arbiter #(
    parameter int DEPTH     = 4,
    parameter int DRAIN_LOW = 1
) (
    input  logic        clk_i,
    input  logic        res_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ready_o,
    input  logic        ld_valid_i,
    input  logic [4:0]  ld_rd_i,
    input  logic [31:0] ld_data_i,
    output logic        ld_ready_o,
    input  logic [4:0]  qry_rd_i,
    output logic        qry_hit_o,
    output logic [4:0]  rw_rf_o,
    output logic [31:0] dw_rf_o,
    output logic        we_rf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LOW_C   = CW'(DRAIN_LOW);

    typedef enum logic {
        NORM  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     fifo_rd_q   [DEPTH];
    logic [31:0]    fifo_data_q [DEPTH];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [4:0]     rw_q;
    logic [31:0]    dw_q;
    logic           we_q;

    logic           alu_acc, ld_acc;
    logic           enq, deq, bypass, issue;
    logic [4:0]     issue_rd;
    logic [31:0]    issue_data;
    logic           qry_match;
    logic [PW-1:0]  off;

    // Readies depend only on registered state (and reset), never on the valids.
    assign ld_ready_o  = res_i & (count_q < DEPTH_C);
    assign alu_ready_o = res_i & (state_q == NORM);
    assign alu_acc     = alu_valid_i & alu_ready_o;
    assign ld_acc      = ld_valid_i & ld_ready_o;

    always_comb begin
        deq        = 1'b0;
        bypass     = 1'b0;
        enq        = 1'b0;
        issue      = 1'b0;
        issue_rd   = rw_q;
        issue_data = dw_q;

        if (state_q == DRAIN) begin
            deq = (count_q != '0);
        end else begin
            deq = !alu_acc && (count_q != '0);
        end

`ifdef WB_LOAD_BYPASS_EN
        bypass = (state_q == NORM) && (count_q == '0) && !alu_acc
                 && ld_acc && (ld_rd_i != 5'd0);
`else
        bypass = 1'b0;
`endif

        enq = ld_acc && (ld_rd_i != 5'd0) && !bypass;

        // An accepted ALU beat owns the slot even when rd==0 drops it.
        if (alu_acc) begin
            issue      = (alu_rd_i != 5'd0);
            issue_rd   = alu_rd_i;
            issue_data = alu_data_i;
        end else if (deq) begin
            issue      = 1'b1;
            issue_rd   = fifo_rd_q[rptr_q];
            issue_data = fifo_data_q[rptr_q];
        end else if (bypass) begin
            issue      = 1'b1;
            issue_rd   = ld_rd_i;
            issue_data = ld_data_i;
        end

        count_d = count_q + CW'(enq) - CW'(deq);

        state_d = state_q;
        if (state_q == NORM && count_d == DEPTH_C) begin
            state_d = DRAIN;
        end else if (state_q == DRAIN && count_d <= LOW_C) begin
            state_d = NORM;
        end
    end

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            state_q <= NORM;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rw_q    <= '0;
            dw_q    <= '0;
            we_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            we_q    <= issue;
            if (issue) begin
                rw_q <= issue_rd;
                dw_q <= issue_data;
            end
            if (enq) begin
                fifo_rd_q[wptr_q]   <= ld_rd_i;
                fifo_data_q[wptr_q] <= ld_data_i;
                wptr_q              <= wptr_q + 1'b1;
            end
            if (deq) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        off       = '0;
        qry_match = we_q && (rw_q == qry_rd_i);
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rptr_q;
            if (({1'b0, off} < count_q) && (fifo_rd_q[i] == qry_rd_i)) begin
                qry_match = 1'b1;
            end
        end
    end

    assign qry_hit_o = (qry_rd_i != 5'd0) && qry_match;
    assign rw_rf_o   = rw_q;
    assign dw_rf_o   = dw_q;
    assign we_rf_o   = we_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed self-checking bench for rf_writeback_arbiter; expectations follow WB_LOAD_BYPASS_EN when it is defined.
module tb_rf_writeback_arbiter;
    logic        clk_i = 1'b0;
    logic        res_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        alu_ready_o;
    logic        ld_valid_i;
    logic [4:0]  ld_rd_i;
    logic [31:0] ld_data_i;
    logic        ld_ready_o;
    logic [4:0]  qry_rd_i;
    logic        qry_hit_o;
    logic [4:0]  rw_rf_o;
    logic [31:0] dw_rf_o;
    logic        we_rf_o;

    int n_checks = 0;
    int n_errors = 0;

    rf_writeback_arbiter #(.DEPTH(4), .DRAIN_LOW(1)) dut (
        .clk_i       (clk_i),
        .res_i       (res_i),
        .alu_valid_i (alu_valid_i),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .alu_ready_o (alu_ready_o),
        .ld_valid_i  (ld_valid_i),
        .ld_rd_i     (ld_rd_i),
        .ld_data_i   (ld_data_i),
        .ld_ready_o  (ld_ready_o),
        .qry_rd_i    (qry_rd_i),
        .qry_hit_o   (qry_hit_o),
        .rw_rf_o     (rw_rf_o),
        .dw_rf_o     (dw_rf_o),
        .we_rf_o     (we_rf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        alu_valid_i = 1'b0;
        alu_rd_i    = '0;
        alu_data_i  = '0;
        ld_valid_i  = 1'b0;
        ld_rd_i     = '0;
        ld_data_i   = '0;
    endtask

    initial begin
        res_i    = 1'b0;
        qry_rd_i = '0;
        idle();
        #12;
        check("rst_we", we_rf_o, 0);
        check("rst_rw", rw_rf_o, 0);
        check("rst_dw", dw_rf_o, 0);
        check("rst_alu_rdy", alu_ready_o, 0);
        check("rst_ld_rdy", ld_ready_o, 0);
        tick();
        res_i = 1'b1;
        tick();
        check("post_rst_alu_rdy", alu_ready_o, 1);
        check("post_rst_ld_rdy", ld_ready_o, 1);

        // Test 1: three loads queued behind ALU traffic, then reset mid-stream
        for (int i = 1; i <= 3; i++) begin
            alu_valid_i = 1'b1;
            alu_rd_i    = 5'd10;
            alu_data_i  = 32'hA0A0_0000 + i;
            ld_valid_i  = 1'b1;
            ld_rd_i     = 5'(i);
            ld_data_i   = 32'h0000_1000 + i;
            tick();
        end
        idle();
        qry_rd_i = 5'd1;
        #1;
        check("t1_qry_before_rst", qry_hit_o, 1);
        res_i = 1'b0;
        #1;
        check("t1_we_in_rst", we_rf_o, 0);
        check("t1_qry_in_rst", qry_hit_o, 0);
        tick();
        res_i = 1'b1;
        tick();
        check("t1_no_stale_we0", we_rf_o, 0);
        tick();
        check("t1_no_stale_we1", we_rf_o, 0);
        check("t1_qry_after", qry_hit_o, 0);
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd11;
        alu_data_i  = 32'h1111_2222;
        tick();
        idle();
        check("t1_new_we", we_rf_o, 1);
        check("t1_new_rw", rw_rf_o, 11);
        check("t1_new_dw", dw_rf_o, 32'h1111_2222);

        // Test 2: single ALU write, one-cycle pulse, address/data hold
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd5;
        alu_data_i  = 32'hDEAD_BEEF;
        tick();
        idle();
        check("t2_we", we_rf_o, 1);
        check("t2_rw", rw_rf_o, 5);
        check("t2_dw", dw_rf_o, 32'hDEAD_BEEF);
        tick();
        check("t2_we_off", we_rf_o, 0);
        check("t2_rw_hold", rw_rf_o, 5);
        check("t2_dw_hold", dw_rf_o, 32'hDEAD_BEEF);

        // Test 3: ALU every cycle fills the FIFO, DRAIN empties it to DRAIN_LOW
        for (int i = 1; i <= 4; i++) begin
            alu_valid_i = 1'b1;
            alu_rd_i    = 5'(20 + i);
            alu_data_i  = 32'h0000_2000 + i;
            ld_valid_i  = 1'b1;
            ld_rd_i     = 5'(i);
            ld_data_i   = 32'd100 + i;
            check("t3_ld_rdy_fill", ld_ready_o, 1);
            tick();
            check("t3_alu_we", we_rf_o, 1);
            check("t3_alu_rw", rw_rf_o, 32'(20 + i));
        end
        check("t3_full_ld_rdy", ld_ready_o, 0);
        check("t3_drain_alu_rdy", alu_ready_o, 0);
        alu_rd_i   = 5'd30;
        alu_data_i = 32'h0000_3030;
        ld_rd_i    = 5'd5;
        ld_data_i  = 32'd105;
        tick();
        ld_valid_i = 1'b0;
        check("t3_d1_rw", rw_rf_o, 1);
        check("t3_d1_dw", dw_rf_o, 101);
        check("t3_d1_alu_rdy", alu_ready_o, 0);
        qry_rd_i = 5'd5;
        #1;
        check("t3_held_not_queued", qry_hit_o, 0);
        tick();
        check("t3_d2_rw", rw_rf_o, 2);
        check("t3_d2_alu_rdy", alu_ready_o, 0);
        tick();
        check("t3_d3_rw", rw_rf_o, 3);
        check("t3_d3_we", we_rf_o, 1);
        check("t3_norm_alu_rdy", alu_ready_o, 1);
        tick();
        check("t3_alu_after_rw", rw_rf_o, 30);
        check("t3_alu_after_dw", dw_rf_o, 32'h0000_3030);
        idle();
        qry_rd_i = 5'd4;
        #1;
        check("t3_qry_rd4", qry_hit_o, 1);
        tick();
        check("t3_d4_we", we_rf_o, 1);
        check("t3_d4_rw", rw_rf_o, 4);
        check("t3_d4_dw", dw_rf_o, 104);
        tick();
        check("t3_empty_we", we_rf_o, 0);
        check("t3_qry_gone", qry_hit_o, 0);

        // Test 4: rd==0 beats complete the handshake but never write
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd0;
        alu_data_i  = 32'h0BAD_0BAD;
        ld_valid_i  = 1'b1;
        ld_rd_i     = 5'd0;
        ld_data_i   = 32'h0BAD_1111;
        qry_rd_i    = 5'd0;
        #1;
        check("t4_alu_rdy", alu_ready_o, 1);
        check("t4_ld_rdy", ld_ready_o, 1);
        tick();
        idle();
        check("t4_we0", we_rf_o, 0);
        check("t4_rw_hold", rw_rf_o, 4);
        tick();
        check("t4_we1", we_rf_o, 0);
        tick();
        check("t4_we2", we_rf_o, 0);
        check("t4_qry0", qry_hit_o, 0);

        // Test 5: QRY_HIT tracks a queued load until its write retires
        ld_valid_i = 1'b1;
        ld_rd_i    = 5'd7;
        ld_data_i  = 32'h0000_0077;
        qry_rd_i   = 5'd7;
        tick();
        idle();
`ifdef WB_LOAD_BYPASS_EN
        check("t5_byp_we", we_rf_o, 1);
        check("t5_byp_rw", rw_rf_o, 7);
        check("t5_byp_hit", qry_hit_o, 1);
        tick();
        check("t5_byp_we_off", we_rf_o, 0);
        check("t5_byp_hit_off", qry_hit_o, 0);
`else
        check("t5_queued_hit", qry_hit_o, 1);
        check("t5_queued_we", we_rf_o, 0);
        qry_rd_i = 5'd0;
        #1;
        check("t5_qry_zero", qry_hit_o, 0);
        qry_rd_i = 5'd7;
        tick();
        check("t5_we", we_rf_o, 1);
        check("t5_rw", rw_rf_o, 7);
        check("t5_dw", dw_rf_o, 32'h0000_0077);
        check("t5_hit_at_we", qry_hit_o, 1);
        tick();
        check("t5_we_off", we_rf_o, 0);
        check("t5_hit_off", qry_hit_o, 0);
`endif
        qry_rd_i = 5'd0;

        // Test 6: single load on an idle arbiter, latency depends on bypass
        ld_valid_i = 1'b1;
        ld_rd_i    = 5'd9;
        ld_data_i  = 32'h0000_0099;
        tick();
        idle();
`ifdef WB_LOAD_BYPASS_EN
        check("t6_n1_we", we_rf_o, 1);
        check("t6_n1_rw", rw_rf_o, 9);
        check("t6_n1_dw", dw_rf_o, 32'h0000_0099);
        tick();
        check("t6_n2_we", we_rf_o, 0);
`else
        check("t6_n1_we", we_rf_o, 0);
        tick();
        check("t6_n2_we", we_rf_o, 1);
        check("t6_n2_rw", rw_rf_o, 9);
        check("t6_n2_dw", dw_rf_o, 32'h0000_0099);
`endif
        tick();
        check("t6_done_we", we_rf_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
